// File: rtl/apb_uart_tx_slave.sv
// APB-programmed UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) with a small TX FIFO.
// Zero-wait-state APB; a frame starts the cycle after its pop; writes into a full FIFO are dropped with PSLVERR.
`timescale 1ns/1ps
module apb_uart_tx_slave #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [3:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       tx,
  output logic       irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       access, wr_acc, rd_acc;
  logic       sel_data, sel_stat, sel_ctrl;
  logic       full, empty, busy, push, pop, bit_end, can_start;
  logic [4:0] count_ext;
  logic [2:0] count_sat;
  logic [7:0] status;

  assign access   = PSEL & PENABLE;
  assign wr_acc   = access & PWRITE;
  assign rd_acc   = access & ~PWRITE;
  assign sel_data = (PADDR == 4'h0);
  assign sel_stat = (PADDR == 4'h4);
  assign sel_ctrl = (PADDR == 4'h8);

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign push      = wr_acc & sel_data & ~full;
  assign can_start = ctrl_q[0] & ~empty;

  assign count_ext = 5'(count_q);
  assign count_sat = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];
  assign status    = {2'b00, count_sat, empty, full, busy};

  assign PREADY  = access;
  assign PSLVERR = access & (~(sel_data | sel_stat | sel_ctrl)
                             | (PWRITE & sel_stat)
                             | (PWRITE & sel_data & full));
  assign tx      = tx_q;
  assign irq     = ctrl_q[1] & empty & ~busy;

  always_comb begin
    PRDATA = 8'h00;
    if (rd_acc) begin
      if (sel_stat)      PRDATA = status;
      else if (sel_ctrl) PRDATA = {6'b0, ctrl_q};
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_acc & sel_ctrl) ctrl_d = PWDATA[1:0];
  end

  // Transmit sequencer: tx is registered, so each state's line level is loaded on the edge that enters it.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bit_end = (cyc_q == LAST_CYC);
    if (state_q != S_IDLE) cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          byte_d  = mem_q[rptr_q];
          cyc_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = byte_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^byte_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (can_start) begin
            pop     = 1'b1;
            byte_d  = mem_q[rptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // The full check uses the pre-edge count, so a same-edge pop never makes room for a push.
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'h00;
      tx_q    <= 1'b1;
      ctrl_q  <= 2'b00;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      ctrl_q  <= ctrl_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wptr_q] <= PWDATA;
  end

endmodule
